i2c_init_sequencer: RTL and testbench

Table-driven sequencer that configures external I2C devices (video decoder, codec) after power-up by driving the team's I2C master. It reads a table of register writes one entry per transaction, issues one single-byte write per entry, and inserts programmable delays. With readback enabled, it re-reads and checks each register. It sits between the board reset/start logic and the I2C master's `request`/`WR`/`length`/`address`/`sub_address`/`txReg`/`busy`/`DE`/`rxReg` ports.

---
 rtl/i2c_init_sequencer_if.sv | 23 ++
 rtl/i2c_init_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_init_sequencer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_init_sequencer_if.sv
// i2c_init_sequencer_if: request/transfer bundle between the init sequencer
// (master modport) and the I2C byte master it drives (slave modport).
interface i2c_init_sequencer_if;
  logic       i2c_request;
  logic       i2c_wr;
  logic [7:0] i2c_length;
  logic [6:0] i2c_address;
  logic [7:0] i2c_sub_address;
  logic [7:0] i2c_tx;
  logic       i2c_busy;
  logic       i2c_de;
  logic [7:0] i2c_rx;

  modport master (
    output i2c_request, i2c_wr, i2c_length, i2c_address, i2c_sub_address, i2c_tx,
    input  i2c_busy, i2c_de, i2c_rx
  );

  modport slave (
    input  i2c_request, i2c_wr, i2c_length, i2c_address, i2c_sub_address, i2c_tx,
    output i2c_busy, i2c_de, i2c_rx
  );
endinterface

// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer: walks a table of single-byte I2C register writes after
// power-up, with programmable delay entries (device address 7'h7F).
// Optional readback check of every write is built when I2C_SEQ_VERIFY_EN is defined.
module i2c_init_sequencer #(
  parameter int unsigned TABLE_DEPTH = 64,
  parameter int unsigned TIMEOUT     = 4096,
  parameter int unsigned DELAY_UNIT  = 50000
) (
  input  logic                           clk_50,
  input  logic                           reset,
  input  logic                           start,
  output logic [$clog2(TABLE_DEPTH)-1:0] tbl_index,
  input  logic [23:0]                    tbl_entry,
  i2c_init_sequencer_if.master           bus,
  output logic                           running,
  output logic                           done,
  output logic                           error,
  output logic [$clog2(TABLE_DEPTH)-1:0] err_index
);
  localparam int unsigned IW = $clog2(TABLE_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned DW = $clog2(255 * DELAY_UNIT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_REQ, S_XFER, S_DELAY, S_NEXT, S_DONE, S_ERROR
`ifdef I2C_SEQ_VERIFY_EN
    , S_VERIFY
`endif
  } state_t;

  state_t         state, state_d;
  logic [IW-1:0]  index_d, err_index_d;
  logic           running_d, done_d, error_d;
  logic           request, request_d, wr, wr_d;
  logic [7:0]     length, length_d;
  logic [6:0]     address, address_d;
  logic [7:0]     sub_address, sub_address_d, tx, tx_d;
  logic [TW-1:0]  tmo_cnt, tmo_cnt_d;
  logic [DW-1:0]  dly_cnt, dly_cnt_d;
  logic           busy_r;
`ifdef I2C_SEQ_VERIFY_EN
  logic           de_r, de_prev, rd_phase, rd_phase_d, rx_valid, rx_valid_d;
  logic [7:0]     rx_cap, rx_cap_d;
`else
  logic           unused_rx;
  assign unused_rx = ^{bus.i2c_rx, bus.i2c_de};
`endif

  assign bus.i2c_request     = request;
  assign bus.i2c_wr          = wr;
  assign bus.i2c_length      = length;
  assign bus.i2c_address     = address;
  assign bus.i2c_sub_address = sub_address;
  assign bus.i2c_tx          = tx;

  // State, datapath and output registers; master status is registered once before use.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state       <= S_IDLE;
      tbl_index   <= '0;
      err_index   <= '0;
      running     <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      request     <= 1'b0;
      wr          <= 1'b0;
      length      <= '0;
      address     <= '0;
      sub_address <= '0;
      tx          <= '0;
      tmo_cnt     <= '0;
      dly_cnt     <= '0;
      busy_r      <= 1'b0;
`ifdef I2C_SEQ_VERIFY_EN
      de_r        <= 1'b0;
      de_prev     <= 1'b0;
      rd_phase    <= 1'b0;
      rx_valid    <= 1'b0;
      rx_cap      <= '0;
`endif
    end else begin
      state       <= state_d;
      tbl_index   <= index_d;
      err_index   <= err_index_d;
      running     <= running_d;
      done        <= done_d;
      error       <= error_d;
      request     <= request_d;
      wr          <= wr_d;
      length      <= length_d;
      address     <= address_d;
      sub_address <= sub_address_d;
      tx          <= tx_d;
      tmo_cnt     <= tmo_cnt_d;
      dly_cnt     <= dly_cnt_d;
      busy_r      <= bus.i2c_busy;
`ifdef I2C_SEQ_VERIFY_EN
      de_r        <= bus.i2c_de;
      de_prev     <= de_r;
      rd_phase    <= rd_phase_d;
      rx_valid    <= rx_valid_d;
      rx_cap      <= rx_cap_d;
`endif
    end
  end

  // Next-state and next-output decode; request is only held while waiting in REQ.
  always_comb begin
    state_d       = state;
    index_d       = tbl_index;
    err_index_d   = err_index;
    running_d     = running;
    done_d        = done;
    error_d       = error;
    request_d     = 1'b0;
    wr_d          = wr;
    length_d      = length;
    address_d     = address;
    sub_address_d = sub_address;
    tx_d          = tx;
    tmo_cnt_d     = tmo_cnt;
    dly_cnt_d     = dly_cnt;
`ifdef I2C_SEQ_VERIFY_EN
    rd_phase_d    = rd_phase;
    rx_valid_d    = rx_valid;
    rx_cap_d      = rx_cap;
    if (de_r && !de_prev && rd_phase) begin
      rx_cap_d   = bus.i2c_rx;
      rx_valid_d = 1'b1;
    end
`endif
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d     = S_FETCH;
          index_d     = '0;
          done_d      = 1'b0;
          error_d     = 1'b0;
          err_index_d = '0;
          running_d   = 1'b1;
        end
      end
      S_FETCH: begin
        if (tbl_entry[23]) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          running_d = 1'b0;
        end else if (tbl_entry[22:16] == 7'h7F) begin
          dly_cnt_d = DW'(tbl_entry[7:0]) * DW'(DELAY_UNIT);
          state_d   = S_DELAY;
        end else begin
          address_d     = tbl_entry[22:16];
          sub_address_d = tbl_entry[15:8];
          tx_d          = tbl_entry[7:0];
          wr_d          = 1'b1;
          length_d      = 8'd1;
          request_d     = 1'b1;
          tmo_cnt_d     = '0;
          state_d       = S_REQ;
`ifdef I2C_SEQ_VERIFY_EN
          rd_phase_d    = 1'b0;
`endif
        end
      end
      S_REQ: begin
        if (busy_r) begin
          state_d = S_XFER;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          state_d     = S_ERROR;
          error_d     = 1'b1;
          running_d   = 1'b0;
          err_index_d = tbl_index;
        end else begin
          request_d = 1'b1;
          tmo_cnt_d = tmo_cnt + TW'(1);
        end
      end
      S_XFER: begin
        if (!busy_r) begin
`ifdef I2C_SEQ_VERIFY_EN
          if (!rd_phase) begin
            state_d = S_VERIFY;
          end else if (rx_valid && (rx_cap == tx)) begin
            state_d = S_NEXT;
          end else begin
            state_d     = S_ERROR;
            error_d     = 1'b1;
            running_d   = 1'b0;
            err_index_d = tbl_index;
          end
`else
          state_d = S_NEXT;
`endif
        end
      end
`ifdef I2C_SEQ_VERIFY_EN
      S_VERIFY: begin
        wr_d       = 1'b0;
        length_d   = 8'd1;
        request_d  = 1'b1;
        tmo_cnt_d  = '0;
        rd_phase_d = 1'b1;
        rx_valid_d = 1'b0;
        state_d    = S_REQ;
      end
`endif
      S_DELAY: begin
        if (dly_cnt == '0) state_d = S_NEXT;
        else               dly_cnt_d = dly_cnt - DW'(1);
      end
      S_NEXT: begin
        if (tbl_index == IW'(TABLE_DEPTH - 1)) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          running_d = 1'b0;
        end else begin
          index_d = tbl_index + IW'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb_i2c_init_sequencer: randomized tables checked against a table-walk model;
// a behavioural I2C master answers requests and logs every transaction.
module tb_i2c_init_sequencer;
  localparam int unsigned TABLE_DEPTH = 16;
  localparam int unsigned TIMEOUT     = 100;
  localparam int unsigned DELAY_UNIT  = 10;
  localparam int unsigned IW          = $clog2(TABLE_DEPTH);
  localparam int BUSY_DLY = 10;
  localparam int BUSY_LEN = 200;
`ifdef I2C_SEQ_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  typedef struct {
    bit       wr;
    bit [6:0] addr;
    bit [7:0] sub;
    bit [7:0] data;
    bit [7:0] len;
    int       gap;
    int       t;
  } txn_t;

  logic          clk_50 = 1'b0;
  logic          reset  = 1'b1;
  logic          start  = 1'b0;
  logic [IW-1:0] tbl_index, err_index;
  logic [23:0]   tbl_entry;
  logic          running, done, error;
  logic [23:0]   tbl [TABLE_DEPTH];

  txn_t log_q[$];
  txn_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  i2c_init_sequencer_if bus();

  i2c_init_sequencer #(
    .TABLE_DEPTH(TABLE_DEPTH), .TIMEOUT(TIMEOUT), .DELAY_UNIT(DELAY_UNIT)
  ) dut (
    .clk_50(clk_50), .reset(reset), .start(start), .tbl_index(tbl_index),
    .tbl_entry(tbl_entry), .bus(bus), .running(running), .done(done),
    .error(error), .err_index(err_index)
  );

  always #5 clk_50 = ~clk_50;
  assign tbl_entry = tbl[tbl_index];

  // Behavioural I2C master: busy rises BUSY_DLY cycles into a request, lasts BUSY_LEN.
  bit         mact, mread, req_prev;
  int         mcnt, cyc, last_fall;
  bit         never_busy = 1'b0;
  logic [7:0] rx_xor = 8'h00;
  always @(posedge clk_50) begin
    cyc      <= cyc + 1;
    req_prev <= (bus.i2c_request === 1'b1);
    if (bus.i2c_request === 1'b1 && !req_prev)
      log_q.push_back('{bus.i2c_wr, bus.i2c_address, bus.i2c_sub_address, bus.i2c_tx,
                        bus.i2c_length, cyc - last_fall, cyc});
    if (!mact) begin
      bus.i2c_busy <= 1'b0;
      bus.i2c_de   <= 1'b0;
      bus.i2c_rx   <= 8'h00;
      if (bus.i2c_request === 1'b1 && !never_busy) begin
        if (mcnt == BUSY_DLY - 1) begin
          mact <= 1'b1; mread <= !bus.i2c_wr; bus.i2c_busy <= 1'b1; mcnt <= 0;
        end else mcnt <= mcnt + 1;
      end else mcnt <= 0;
    end else begin
      mcnt       <= mcnt + 1;
      bus.i2c_de <= mread && (mcnt == BUSY_LEN / 2);
      if (mread && mcnt == BUSY_LEN / 2) bus.i2c_rx <= bus.i2c_tx ^ rx_xor;
      if (mcnt == BUSY_LEN - 1) begin
        bus.i2c_busy <= 1'b0; mact <= 1'b0; mcnt <= 0; last_fall <= cyc;
      end
    end
  end

  // Reference: walk entries until end marker or table end, skipping delay entries.
  function automatic void model_walk();
    logic [23:0] e;
    exp_q.delete();
    for (int i = 0; i < int'(TABLE_DEPTH); i++) begin
      e = tbl[i];
      if (e[23]) break;
      if (e[22:16] == 7'h7F) continue;
      exp_q.push_back('{1'b1, e[22:16], e[15:8], e[7:0], 8'd1, 0, 0});
      if (VERIFY) exp_q.push_back('{1'b0, e[22:16], e[15:8], e[7:0], 8'd1, 0, 0});
    end
  endfunction

  function automatic bit log_matches();
    if (log_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i])
      if (log_q[i].wr != exp_q[i].wr || log_q[i].addr != exp_q[i].addr ||
          log_q[i].sub != exp_q[i].sub || log_q[i].data != exp_q[i].data ||
          log_q[i].len != exp_q[i].len) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [23:0] rand_entry(bit allow_delay);
    if (allow_delay && $urandom_range(0, 4) == 0)
      return {1'b0, 7'h7F, 8'($urandom), 8'($urandom_range(0, 3))};
    return {1'b0, 7'($urandom_range(0, 126)), 8'($urandom), 8'($urandom)};
  endfunction

  task automatic pulse_start();
    @(negedge clk_50); start = 1'b1;
    @(negedge clk_50); start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (done || error) break;
      @(negedge clk_50);
    end
    ok = done || error;
  endtask

  task automatic wait_master_idle();
    for (int i = 0; i < 2 * BUSY_LEN; i++) begin
      if (!mact && !bus.i2c_busy) break;
      @(negedge clk_50);
    end
    repeat (5) @(negedge clk_50);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_50);
    n_cmp++;
    if ({running, done, error, err_index, tbl_index} !== '0) begin
      n_err++; $display("FAIL reset_status: got %0h want 0", {running, done, error, err_index, tbl_index});
    end
    n_cmp++;
    if ({bus.i2c_request, bus.i2c_wr, bus.i2c_length, bus.i2c_address, bus.i2c_sub_address, bus.i2c_tx} !== 33'd0) begin
      n_err++; $display("FAIL reset_bus: got %0h want 0",
        {bus.i2c_request, bus.i2c_wr, bus.i2c_length, bus.i2c_address, bus.i2c_sub_address, bus.i2c_tx});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk_50);
  endtask

  task automatic test_basic();
    bit ok;
    tbl[0] = {1'b0, 7'h20, 8'h00, 8'h5A};
    tbl[1] = {1'b0, 7'h20, 8'h01, 8'hA5};
    tbl[2] = {1'b1, 23'h0};
    model_walk();
    for (int run = 0; run < 2; run++) begin
      log_q.delete();
      pulse_start();
      n_cmp++;
      if (tbl_index !== '0 || running !== 1'b1 || done !== 1'b0 || bus.i2c_request !== 1'b0) begin
        n_err++; $display("FAIL basic_accept run%0d: idx=%0d run=%b done=%b req=%b want 0/1/0/0",
                          run, tbl_index, running, done, bus.i2c_request);
      end
      @(negedge clk_50);
      n_cmp++;
      if (bus.i2c_request !== 1'b1) begin
        n_err++; $display("FAIL basic_req_latency run%0d: req=%b want 1", run, bus.i2c_request);
      end
      wait_end(3 * 600, ok);
      n_cmp++;
      if (!ok || done !== 1'b1 || error !== 1'b0 || running !== 1'b0) begin
        n_err++; $display("FAIL basic_end run%0d: done=%b error=%b running=%b want 1/0/0", run, done, error, running);
      end
      n_cmp++;
      if (!log_matches()) begin
        n_err++; $display("FAIL basic_txns run%0d: got %0d txns want %0d (or field diff)", run, log_q.size(), exp_q.size());
      end
      n_cmp++;
      if (tbl_index !== IW'(2)) begin
        n_err++; $display("FAIL basic_end_index run%0d: got %0d want 2", run, tbl_index);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < int'(TABLE_DEPTH); i++) tbl[i] = rand_entry(1'b1);
      tbl[n] = {1'b1, 23'($urandom)};
      model_walk();
      log_q.delete();
      pulse_start();
      wait_end((n + 1) * 600, ok);
      n_cmp++;
      if (!ok || done !== 1'b1 || error !== 1'b0) begin
        n_err++; $display("FAIL random_end it%0d: done=%b error=%b want 1/0", it, done, error);
      end
      n_cmp++;
      if (!log_matches()) begin
        n_err++; $display("FAIL random_txns it%0d: got %0d txns want %0d (or field diff)", it, log_q.size(), exp_q.size());
      end
      n_cmp++;
      if (tbl_index !== IW'(n)) begin
        n_err++; $display("FAIL random_end_index it%0d: got %0d want %0d", it, tbl_index, n);
      end
    end
  endtask

  task automatic test_delay();
    bit ok;
    int gap [2];
    int w2 = VERIFY ? 2 : 1;
    for (int run = 0; run < 2; run++) begin
      tbl[0] = {1'b0, 7'h21, 8'h10, 8'h11};
      tbl[1] = {1'b0, 7'h7F, 8'h00, (run == 0) ? 8'd0 : 8'd3};
      tbl[2] = {1'b0, 7'h22, 8'h20, 8'h22};
      tbl[3] = {1'b1, 23'h0};
      model_walk();
      log_q.delete();
      pulse_start();
      wait_end(4 * 600, ok);
      n_cmp++;
      if (!ok || done !== 1'b1 || !log_matches()) begin
        n_err++; $display("FAIL delay_run%0d: done=%b txns=%0d want 1/%0d", run, done, log_q.size(), exp_q.size());
        gap[run] = 0;
      end else gap[run] = log_q[w2].gap;
    end
    n_cmp++;
    if (gap[1] - gap[0] < 3 * int'(DELAY_UNIT) - 1 || gap[1] - gap[0] > 3 * int'(DELAY_UNIT) + 1) begin
      n_err++; $display("FAIL delay_extra: got %0d cycles want %0d +-1", gap[1] - gap[0], 3 * DELAY_UNIT);
    end
    n_cmp++;
    if (gap[1] < 3 * int'(DELAY_UNIT) || gap[1] > 3 * int'(DELAY_UNIT) + 12) begin
      n_err++; $display("FAIL delay_gap: got %0d want %0d..%0d", gap[1], 3 * DELAY_UNIT, 3 * DELAY_UNIT + 12);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int k, t_err;
    never_busy = 1'b1;
    for (int run = 0; run < 2; run++) begin
      k = (run == 0) ? 0 : 2;
      for (int i = 0; i < k; i++) tbl[i] = {1'b0, 7'h7F, 8'h00, 8'h00};
      tbl[k]     = {1'b0, 7'h30, 8'h05, 8'h77};
      tbl[k + 1] = {1'b1, 23'h0};
      log_q.delete();
      pulse_start();
      wait_end(4 * int'(TIMEOUT), ok);
      t_err = cyc;
      n_cmp++;
      if (!ok || error !== 1'b1 || done !== 1'b0 || running !== 1'b0) begin
        n_err++; $display("FAIL timeout_flags k%0d: error=%b done=%b running=%b want 1/0/0", k, error, done, running);
      end
      n_cmp++;
      if (err_index !== IW'(k)) begin
        n_err++; $display("FAIL timeout_err_index: got %0d want %0d", err_index, k);
      end
      n_cmp++;
      if (log_q.size() != 1 || t_err - log_q[0].t < int'(TIMEOUT) - 1 || t_err - log_q[0].t > int'(TIMEOUT) + 2) begin
        n_err++; $display("FAIL timeout_latency k%0d: txns=%0d cycles=%0d want 1/%0d..%0d", k, log_q.size(),
                          (log_q.size() > 0) ? t_err - log_q[0].t : -1, TIMEOUT - 1, TIMEOUT + 2);
      end
      repeat (10) @(negedge clk_50);
      n_cmp++;
      if (bus.i2c_request !== 1'b0 || log_q.size() != 1) begin
        n_err++; $display("FAIL timeout_quiet k%0d: req=%b txns=%0d want 0/1", k, bus.i2c_request, log_q.size());
      end
    end
    never_busy = 1'b0;
  endtask

  task automatic test_full_table();
    bit ok;
    for (int i = 0; i < int'(TABLE_DEPTH); i++) tbl[i] = rand_entry(1'b0);
    model_walk();
    log_q.delete();
    pulse_start();
    wait_end((TABLE_DEPTH + 1) * 600, ok);
    n_cmp++;
    if (!ok || done !== 1'b1 || error !== 1'b0 || tbl_index !== IW'(TABLE_DEPTH - 1)) begin
      n_err++; $display("FAIL full_end: done=%b error=%b idx=%0d want 1/0/%0d", done, error, tbl_index, TABLE_DEPTH - 1);
    end
    repeat (20) @(negedge clk_50);
    n_cmp++;
    if (!log_matches()) begin
      n_err++; $display("FAIL full_txns: got %0d txns want %0d (or field diff)", log_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n_before;
    tbl[0] = {1'b0, 7'h20, 8'h00, 8'h5A};
    tbl[1] = {1'b0, 7'h20, 8'h01, 8'hA5};
    tbl[2] = {1'b1, 23'h0};
    log_q.delete();
    pulse_start();
    for (int i = 0; i < 100 && !bus.i2c_busy; i++) @(negedge clk_50);
    repeat (5) @(negedge clk_50);
    reset = 1'b1;
    @(negedge clk_50);
    n_cmp++;
    if ({running, done, error, err_index, tbl_index, bus.i2c_request, bus.i2c_wr, bus.i2c_length,
         bus.i2c_address, bus.i2c_sub_address, bus.i2c_tx} !== '0) begin
      n_err++; $display("FAIL midreset_outputs: running=%b req=%b addr=%0h tx=%0h want all 0",
                        running, bus.i2c_request, bus.i2c_address, bus.i2c_tx);
    end
    reset = 1'b0;
    n_before = log_q.size();
    wait_master_idle();
    n_cmp++;
    if (bus.i2c_request !== 1'b0 || log_q.size() != n_before) begin
      n_err++; $display("FAIL midreset_quiet: req=%b txns=%0d want 0/%0d", bus.i2c_request, log_q.size(), n_before);
    end
    model_walk();
    log_q.delete();
    pulse_start();
    wait_end(3 * 600, ok);
    n_cmp++;
    if (!ok || done !== 1'b1 || !log_matches()) begin
      n_err++; $display("FAIL midreset_restart: done=%b txns=%0d want 1/%0d", done, log_q.size(), exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    for (int it = 0; it < 2; it++) begin
      n = $urandom_range(2, 4);
      for (int i = 0; i < int'(TABLE_DEPTH); i++) tbl[i] = rand_entry(1'b0);
      tbl[n] = {1'b1, 23'($urandom)};
      model_walk();
      log_q.delete();
      pulse_start();
      n_cmp++;
      if (tbl_index !== '0 || done !== 1'b0) begin
        n_err++; $display("FAIL b2b_restart it%0d: idx=%0d done=%b want 0/0", it, tbl_index, done);
      end
      for (int i = 0; i < 100 && !bus.i2c_busy; i++) @(negedge clk_50);
      pulse_start();
      wait_end((n + 1) * 600, ok);
      n_cmp++;
      if (!ok || done !== 1'b1 || !log_matches()) begin
        n_err++; $display("FAIL b2b_ignored_start it%0d: done=%b txns=%0d want 1/%0d", it, done, log_q.size(), exp_q.size());
      end
    end
  endtask

`ifdef I2C_SEQ_VERIFY_EN
  task automatic test_verify();
    bit ok;
    tbl[0] = {1'b0, 7'h20, 8'h00, 8'h5A};
    tbl[1] = {1'b1, 23'h0};
    rx_xor = 8'h01;
    log_q.delete();
    pulse_start();
    wait_end(3 * 600, ok);
    n_cmp++;
    if (!ok || error !== 1'b1 || done !== 1'b0 || err_index !== '0) begin
      n_err++; $display("FAIL verify_mismatch: error=%b done=%b err_index=%0d want 1/0/0", error, done, err_index);
    end
    n_cmp++;
    if (log_q.size() != 2 || log_q[1].wr != 1'b0) begin
      n_err++; $display("FAIL verify_read_issued: txns=%0d want 2 with read second", log_q.size());
    end
    wait_master_idle();
    rx_xor = 8'h00;
    model_walk();
    log_q.delete();
    pulse_start();
    wait_end(3 * 600, ok);
    n_cmp++;
    if (!ok || done !== 1'b1 || error !== 1'b0 || !log_matches()) begin
      n_err++; $display("FAIL verify_match: done=%b error=%b txns=%0d want 1/0/%0d", done, error, log_q.size(), exp_q.size());
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < int'(TABLE_DEPTH); i++) tbl[i] = 24'h0;
    test_reset();
    test_basic();
    test_random();
    test_delay();
    test_timeout();
    test_full_table();
    test_reset_mid();
    test_back_to_back();
`ifdef I2C_SEQ_VERIFY_EN
    test_verify();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
